mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 63 ++++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester ports (instruction fetch and data load/store),
// the shared single-port memory command/response and the busy flag.
//   master : the arbiter side (drives grants, completions, memory command)
//   slave  : the environment side (requesters and the memory itself)
// Signals:
//   if_req/if_addr           fetch request and address
//   if_gnt/if_done/if_err    fetch accept pulse, completion pulse, error flag
//   if_rdata                 fetched word
//   d_req/d_we/d_addr/d_wdata  data load/store request
//   d_gnt/d_done/d_err/d_rdata data accept, completion, error, load data
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata/mem_ack        memory read data, one-cycle completion strobe
//   busy                     high while a transaction is outstanding
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_done, if_err, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_done, d_err, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_done, if_err, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_done, d_err, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port (fetch / data) arbiter in front of a single-port memory. One
// transaction is outstanding at a time; simultaneous requests alternate
// round-robin, starting with the data port after reset. A transaction ends on
// mem_ack or, if the memory never answers, after TIMEOUT busy cycles with an
// error completion.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    mem_arbiter_if master modport (requesters, memory, busy)
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t            state;
  logic              owner_data;
  logic              data_next;
  logic [7:0]        tmo_cnt;

  logic              grant_data;
  logic [7:0]        tmo_next;
  logic              finish;
  logic [DATA_W-1:0] done_rdata;

  // Data wins when it is the only requester or when it holds the round-robin
  // turn. A completion is either an ack or the timeout; ack takes priority so
  // a same-edge collision is a normal completion. Writes and timeouts return 0.
  always_comb begin
    grant_data = bus.d_req & (~bus.if_req | data_next);
    tmo_next   = tmo_cnt + 8'd1;
    finish     = bus.mem_ack | (tmo_next == TIMEOUT_CNT);
    done_rdata = (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : {DATA_W{1'b0}};
  end

  // Single FSM: grants, done and err are one-cycle pulses cleared by default;
  // the memory command is latched at acceptance and held throughout BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner_data    <= 1'b0;
      data_next     <= 1'b1;
      tmo_cnt       <= 8'd0;
      bus.if_gnt    <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.d_gnt     <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= {DATA_W{1'b0}};
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt  <= 1'b0;
      bus.d_gnt   <= 1'b0;
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.if_err  <= 1'b0;
      bus.d_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state       <= BUSY;
            bus.busy    <= 1'b1;
            owner_data  <= grant_data;
            data_next   <= ~grant_data;
            tmo_cnt     <= 8'd0;
            bus.mem_req <= 1'b1;
            if (grant_data) begin
              bus.d_gnt     <= 1'b1;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
            end else begin
              bus.if_gnt    <= 1'b1;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= {DATA_W{1'b0}};
            end
          end
        end
        BUSY: begin
          if (finish) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            tmo_cnt       <= 8'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            if (owner_data) begin
              bus.d_done  <= 1'b1;
              bus.d_err   <= ~bus.mem_ack;
              bus.d_rdata <= done_rdata;
            end else begin
              bus.if_done  <= 1'b1;
              bus.if_err   <= ~bus.mem_ack;
              bus.if_rdata <= done_rdata;
            end
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Stimulus tasks push the expected completion
// of each accepted transaction into a queue; an independent monitor pops and
// compares whenever a done pulse appears on either port.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_data;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.if_gnt || bus.d_gnt)
        check_output("gnt_exclusive", 64'(bus.if_gnt & bus.d_gnt), 64'd0);
      if (bus.if_done || bus.d_done) begin
        check_output("done_exclusive", 64'(bus.if_done & bus.d_done), 64'd0);
        check_output("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_output("done_port", 64'(bus.d_done), 64'(mon_e.is_data));
          if (mon_e.is_data) begin
            check_output("d_err", 64'(bus.d_err), 64'(mon_e.err));
            check_output("d_rdata", 64'(bus.d_rdata), 64'(mon_e.rdata));
          end else begin
            check_output("if_err", 64'(bus.if_err), 64'(mon_e.err));
            check_output("if_rdata", 64'(bus.if_rdata), 64'(mon_e.rdata));
          end
        end
      end
    end
  end

  task automatic wait_gnt(input bit is_data, output bit got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = is_data ? bus.d_gnt : bus.if_gnt;
    end
  endtask

  // One transaction on one port. ack_delay = k puts mem_ack at the k-th busy
  // edge after acceptance; ack_delay = 0 never acks, so the timeout fires.
  task automatic apply_stimulus(input bit is_data, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ack_delay,
                                input logic [31:0] rdata);
    bit   got;
    int   lat;
    exp_t e;
    @(negedge clk);
    if (is_data) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    wait_gnt(is_data, got);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check_output("grant_seen", 64'(got), 64'd1);
    if (got) begin
      check_output("mem_req", 64'(bus.mem_req), 64'd1);
      check_output("busy_high", 64'(bus.busy), 64'd1);
      check_output("mem_addr", 64'(bus.mem_addr), 64'(addr));
      check_output("mem_we", 64'(bus.mem_we), 64'(we & is_data));
      check_output("mem_wdata", 64'(bus.mem_wdata), is_data ? 64'(wdata) : 64'd0);
      e.is_data = is_data;
      e.err     = (ack_delay == 0);
      e.rdata   = (ack_delay == 0 || (we && is_data)) ? 32'd0 : rdata;
      exp_q.push_back(e);
      bus.mem_rdata = rdata;
      lat = 0;
      while (bus.busy && lat < 40) begin
        if (ack_delay != 0 && lat == ack_delay - 1) bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        lat++;
        if (lat == 1)
          check_output("gnt_one_cycle", 64'(is_data ? bus.d_gnt : bus.if_gnt), 64'd0);
        if (lat < ((ack_delay != 0) ? ack_delay : TIMEOUT))
          check_output("mem_addr_held", 64'(bus.mem_addr), 64'(addr));
      end
      check_output("latency", 64'(lat), 64'((ack_delay != 0) ? ack_delay : TIMEOUT));
      check_output("mem_req_idle", 64'(bus.mem_req), 64'd0);
    end
  endtask

  // Both ports request together; the winner is checked, then the loser, which
  // keeps its request held, must be served after the winner completes.
  task automatic run_conflict(input bit data_first);
    exp_t e;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_A000; bus.d_wdata = 32'h0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0B00;
    @(negedge clk);
    check_output("conflict_d_gnt", 64'(bus.d_gnt), 64'(data_first));
    check_output("conflict_if_gnt", 64'(bus.if_gnt), 64'(!data_first));
    check_output("conflict_addr1", 64'(bus.mem_addr), data_first ? 64'h0000_A000 : 64'h0000_0B00);
    if (data_first) bus.d_req = 1'b0; else bus.if_req = 1'b0;
    e.is_data = data_first; e.err = 1'b0; e.rdata = 32'h1111_1111;
    exp_q.push_back(e);
    bus.mem_rdata = 32'h1111_1111;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_output("conflict_busy_done", 64'(bus.busy), 64'd0);
    check_output("conflict_no_gnt_on_done", 64'(bus.if_gnt | bus.d_gnt), 64'd0);
    @(negedge clk);
    check_output("conflict_second_gnt", 64'(data_first ? bus.if_gnt : bus.d_gnt), 64'd1);
    check_output("conflict_addr2", 64'(bus.mem_addr), data_first ? 64'h0000_0B00 : 64'h0000_A000);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    e.is_data = !data_first; e.err = 1'b0; e.rdata = 32'h2222_2222;
    exp_q.push_back(e);
    bus.mem_rdata = 32'h2222_2222;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_output("conflict_busy_done2", 64'(bus.busy), 64'd0);
  endtask

  // Safety net so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;

    // Reset state
    @(negedge clk);
    check_output("rst_busy", 64'(bus.busy), 64'd0);
    check_output("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check_output("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check_output("rst_gnt", 64'({bus.if_gnt, bus.d_gnt}), 64'd0);
    check_output("rst_done", 64'({bus.if_done, bus.d_done, bus.if_err, bus.d_err}), 64'd0);
    check_output("rst_rdata", 64'(bus.if_rdata | bus.d_rdata), 64'd0);
    reset = 1'b1;

    // First conflict after reset: data then fetch
    run_conflict(1'b1);
    check_output("d_rdata_hold", 64'(bus.d_rdata), 64'h1111_1111);
    check_output("if_rdata_hold", 64'(bus.if_rdata), 64'h2222_2222);

    // Single fetch, ack two cycles after acceptance
    apply_stimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
    check_output("fetch_rdata", 64'(bus.if_rdata), 64'hDEAD_BEEF);
    check_output("d_rdata_untouched", 64'(bus.d_rdata), 64'h1111_1111);

    // Store with immediate ack; junk on mem_rdata must not leak into d_rdata
    apply_stimulus(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_0000);
    check_output("store_rdata", 64'(bus.d_rdata), 64'd0);

    // Data was granted last, so the next conflict goes to fetch
    run_conflict(1'b0);

    // Timeout with no ack
    apply_stimulus(1'b0, 1'b0, 32'h0000_0400, 32'h0, 0, 32'hCAFE_F00D);
    check_output("timeout_rdata", 64'(bus.if_rdata), 64'd0);

    // Ack on the same edge as the timeout completes normally
    apply_stimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0, TIMEOUT, 32'hA5A5_A5A5);
    check_output("collision_rdata", 64'(bus.d_rdata), 64'hA5A5_A5A5);

    // Reset in the middle of a data transaction
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300;
    wait_gnt(1'b1, got);
    bus.d_req = 1'b0;
    check_output("midrst_grant", 64'(got), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_output("midrst_busy", 64'(bus.busy), 64'd0);
    check_output("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    check_output("midrst_no_done", 64'(bus.d_done | bus.if_done), 64'd0);
    reset = 1'b1;
    bus.mem_rdata = 32'h0000_0077;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_output("late_ack_busy", 64'(bus.busy), 64'd0);
    check_output("late_ack_done", 64'(bus.d_done | bus.if_done), 64'd0);
    check_output("late_ack_rdata", 64'(bus.d_rdata), 64'd0);
    @(negedge clk);
    check_output("late_ack_done2", 64'(bus.d_done | bus.if_done), 64'd0);

    // Round-robin pointer returns to data after reset
    run_conflict(1'b1);

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
